// File: rtl/pokemon_renderer.sv
// Pixel renderer for the battle screen: fireballs, waterballs and shield bars on a 96x64 OLED.
// Define SHIELD_BLINK_EN to make an active shield blink (drawn only on odd timer values).
module pokemon_renderer #(
   parameter logic [3:0]  SHIELD_FRAMES = 4'd6,
   parameter logic [15:0] COL_FIRE      = 16'hF800,
   parameter logic [15:0] COL_WATER     = 16'h001F,
   parameter logic [15:0] COL_SHIELD    = 16'hFFE0,
   parameter logic [15:0] COL_BG        = 16'h0000
) (
   input  logic        clk_6p25MHz,
   input  logic        reset_n,
   input  logic        frame_begin,
   input  logic [12:0] pixel_index,
   input  logic [8:0]  FireBall_EN,
   input  logic [8:0]  WaterBall_EN,
   input  logic [62:0] leftX_fb,
   input  logic [62:0] leftX_wb,
   input  logic [5:0]  Shield_EN,
   output logic [15:0] pixel_data
);

   // Shield requests come from the slow logic domain: synchronise, then detect rising edges.
   logic [5:0] shield_s1_reg;
   logic [5:0] shield_s2_reg;
   logic [5:0] shield_s3_reg;
   logic [5:0] shield_rise;

   always_ff @(posedge clk_6p25MHz or negedge reset_n) begin
      if (!reset_n) begin
         shield_s1_reg <= '0;
         shield_s2_reg <= '0;
         shield_s3_reg <= '0;
      end else begin
         shield_s1_reg <= Shield_EN;
         shield_s2_reg <= shield_s1_reg;
         shield_s3_reg <= shield_s2_reg;
      end
   end

   assign shield_rise = shield_s2_reg & ~shield_s3_reg;

   // Ball state is frozen once per frame so a frame never mixes old and new positions.
   logic [8:0]  fire_en_reg;
   logic [8:0]  water_en_reg;
   logic [62:0] fire_x_reg;
   logic [62:0] water_x_reg;

   always_ff @(posedge clk_6p25MHz or negedge reset_n) begin
      if (!reset_n) begin
         fire_en_reg  <= '0;
         water_en_reg <= '0;
         fire_x_reg   <= '0;
         water_x_reg  <= '0;
      end else if (frame_begin) begin
         fire_en_reg  <= FireBall_EN;
         water_en_reg <= WaterBall_EN;
         fire_x_reg   <= leftX_fb;
         water_x_reg  <= leftX_wb;
      end
   end

   logic [5:0] shield_on;

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_timer
         logic [3:0] timer_reg;

         // A fresh edge always reloads, even on a frame_begin cycle.
         always_ff @(posedge clk_6p25MHz or negedge reset_n) begin
            if (!reset_n) begin
               timer_reg <= '0;
            end else if (shield_rise[gi]) begin
               timer_reg <= SHIELD_FRAMES;
            end else if (frame_begin && (timer_reg != 4'd0)) begin
               timer_reg <= timer_reg - 4'd1;
            end
         end

`ifdef SHIELD_BLINK_EN
         assign shield_on[gi] = timer_reg[0];
`else
         assign shield_on[gi] = (timer_reg != 4'd0);
`endif
      end
   endgenerate

   // Stage 1: split the linear index into column/row; 64 rows * 96 = 6144 marks the end.
   logic [12:0] row_full;
   logic [12:0] col_full;
   logic [6:0]  x_reg;
   logic [5:0]  y_reg;
   logic        oor_reg;

   assign row_full = pixel_index / 13'd96;
   assign col_full = pixel_index - (row_full * 13'd96);

   always_ff @(posedge clk_6p25MHz or negedge reset_n) begin
      if (!reset_n) begin
         x_reg   <= '0;
         y_reg   <= '0;
         oor_reg <= 1'b0;
      end else begin
         x_reg   <= col_full[6:0];
         y_reg   <= row_full[5:0];
         oor_reg <= (|row_full[12:6]) | (|col_full[12:7]);
      end
   end

   // Stage 2: per-object hit tests against the registered coordinate.
   logic [8:0] fire_hit;
   logic [8:0] water_hit;
   logic [5:0] shield_hit;

   generate
      for (gi = 0; gi < 9; gi++) begin : g_ball
         localparam logic [5:0] TOP = 6'(6 + 18 * (gi / 3));
         logic [6:0] fire_x;
         logic [6:0] water_x;
         logic       y_in;

         assign fire_x  = fire_x_reg[7*gi +: 7];
         assign water_x = water_x_reg[7*gi +: 7];
         assign y_in    = (y_reg >= TOP) && (y_reg <= TOP + 6'd7);

         // Right edge evaluated at 8 bits so a ball near x=127 cannot wrap to the left side.
         assign fire_hit[gi]  = fire_en_reg[gi] && y_in && (x_reg >= fire_x) &&
                                ({1'b0, x_reg} <= ({1'b0, fire_x} + 8'd7));
         assign water_hit[gi] = water_en_reg[gi] && y_in && (x_reg >= water_x) &&
                                ({1'b0, x_reg} <= ({1'b0, water_x} + 8'd7));
      end

      for (gi = 0; gi < 6; gi++) begin : g_shield
         localparam logic [5:0] TOP = 6'(6 + 18 * (gi % 3));
         localparam logic [6:0] XL  = (gi < 3) ? 7'd24 : 7'd70;

         assign shield_hit[gi] = shield_on[gi] &&
                                 (x_reg >= XL) && (x_reg <= XL + 7'd1) &&
                                 (y_reg >= TOP - 6'd4) && (y_reg <= TOP + 6'd11);
      end
   endgenerate

   logic [15:0] colour_next;

   always_comb begin
      colour_next = COL_BG;
      if (oor_reg) begin
         colour_next = COL_BG;
      end else if (|shield_hit) begin
         colour_next = COL_SHIELD;
      end else if (|fire_hit) begin
         colour_next = COL_FIRE;
      end else if (|water_hit) begin
         colour_next = COL_WATER;
      end
   end

   always_ff @(posedge clk_6p25MHz or negedge reset_n) begin
      if (!reset_n) begin
         pixel_data <= '0;
      end else begin
         pixel_data <= colour_next;
      end
   end

endmodule

// File: tb/tb_pokemon_renderer.sv
// Scoreboard bench for pokemon_renderer: random frames, balls and shields checked against a pixel-level model.
`timescale 1ns/1ps
module tb_pokemon_renderer;

   localparam int          SF         = 6;
   localparam logic [15:0] COL_FIRE   = 16'hF800;
   localparam logic [15:0] COL_WATER  = 16'h001F;
   localparam logic [15:0] COL_SHIELD = 16'hFFE0;
   localparam logic [15:0] COL_BG     = 16'h0000;

   logic        clk_6p25MHz  = 1'b0;
   logic        reset_n      = 1'b0;
   logic        frame_begin  = 1'b0;
   logic [12:0] pixel_index  = '0;
   logic [8:0]  FireBall_EN  = '0;
   logic [8:0]  WaterBall_EN = '0;
   logic [62:0] leftX_fb     = '0;
   logic [62:0] leftX_wb     = '0;
   logic [5:0]  Shield_EN    = '0;
   logic [15:0] pixel_data;

   pokemon_renderer #(.SHIELD_FRAMES(4'd6)) dut (
      .clk_6p25MHz (clk_6p25MHz),
      .reset_n     (reset_n),
      .frame_begin (frame_begin),
      .pixel_index (pixel_index),
      .FireBall_EN (FireBall_EN),
      .WaterBall_EN(WaterBall_EN),
      .leftX_fb    (leftX_fb),
      .leftX_wb    (leftX_wb),
      .Shield_EN   (Shield_EN),
      .pixel_data  (pixel_data)
   );

   always #80 clk_6p25MHz = ~clk_6p25MHz;

   int cyc = 0;
   always @(posedge clk_6p25MHz) cyc <= cyc + 1;

   typedef struct {
      int          issue;
      int          idx;
      logic [15:0] exp;
   } txn_t;

   txn_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference state: what the screen should show, in plain integers.
   bit m_fire_en[9];
   int m_fire_x[9];
   bit m_water_en[9];
   int m_water_x[9];
   int m_timer[6];

   function automatic bit shield_vis(int t);
`ifdef SHIELD_BLINK_EN
      return (t % 2) == 1;
`else
      return t != 0;
`endif
   endfunction

   function automatic logic [15:0] model_pixel(int idx);
      int x, y, top, xl;
      if (idx >= 6144) return COL_BG;
      x = idx % 96;
      y = idx / 96;
      for (int s = 0; s < 6; s++) begin
         top = 6 + 18 * (s % 3);
         xl  = (s < 3) ? 24 : 70;
         if (shield_vis(m_timer[s]) && x >= xl && x <= xl + 1 && y >= top - 4 && y <= top + 11)
            return COL_SHIELD;
      end
      for (int i = 0; i < 9; i++) begin
         top = 6 + 18 * (i / 3);
         if (m_fire_en[i] && x >= m_fire_x[i] && x <= m_fire_x[i] + 7 && y >= top && y <= top + 7)
            return COL_FIRE;
      end
      for (int i = 0; i < 9; i++) begin
         top = 6 + 18 * (i / 3);
         if (m_water_en[i] && x >= m_water_x[i] && x <= m_water_x[i] + 7 && y >= top && y <= top + 7)
            return COL_WATER;
      end
      return COL_BG;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 9; i++) begin
         m_fire_en[i] = 0; m_fire_x[i] = 0; m_water_en[i] = 0; m_water_x[i] = 0;
      end
      for (int s = 0; s < 6; s++) m_timer[s] = 0;
   endtask

   task automatic take_snapshot();
      for (int i = 0; i < 9; i++) begin
         m_fire_en[i]  = FireBall_EN[i];
         m_fire_x[i]   = int'(leftX_fb[7*i +: 7]);
         m_water_en[i] = WaterBall_EN[i];
         m_water_x[i]  = int'(leftX_wb[7*i +: 7]);
      end
   endtask

   task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end else begin
         $display("ok   %s data=%h", name, got);
      end
   endtask

   task automatic read_px(int idx);
      txn_t t;
      @(negedge clk_6p25MHz);
      pixel_index = 13'(idx);
      t.issue = cyc;
      t.idx   = idx;
      t.exp   = model_pixel(idx);
      sb.push_back(t);
   endtask

   task automatic drain();
      repeat (3) @(negedge clk_6p25MHz);
   endtask

   task automatic frame_pulse();
      drain();
      @(negedge clk_6p25MHz);
      frame_begin = 1'b1;
      take_snapshot();
      for (int s = 0; s < 6; s++) if (m_timer[s] > 0) m_timer[s]--;
      @(negedge clk_6p25MHz);
      frame_begin = 1'b0;
   endtask

   task automatic shield_pulse(int b, int hold);
      drain();
      @(negedge clk_6p25MHz);
      Shield_EN[b] = 1'b1;
      repeat (hold) @(negedge clk_6p25MHz);
      m_timer[b] = SF;
      Shield_EN[b] = 1'b0;
      repeat (4) @(negedge clk_6p25MHz);
   endtask

   // Edge reaches the timer on the same clock as frame_begin: the load must win.
   task automatic shield_with_frame(int b);
      drain();
      @(negedge clk_6p25MHz);
      Shield_EN[b] = 1'b1;
      repeat (2) @(negedge clk_6p25MHz);
      frame_begin = 1'b1;
      take_snapshot();
      for (int s = 0; s < 6; s++) if (m_timer[s] > 0) m_timer[s]--;
      m_timer[b] = SF;
      @(negedge clk_6p25MHz);
      frame_begin = 1'b0;
      repeat (3) @(negedge clk_6p25MHz);
      Shield_EN[b] = 1'b0;
      repeat (4) @(negedge clk_6p25MHz);
   endtask

   function automatic int pick_idx();
      int k, b, x, y, top;
      k = int'($urandom_range(0, 9));
      if (k == 0) return int'($urandom_range(6144, 8191));
      if (k <= 2) return int'($urandom_range(0, 6143));
      if (k <= 5) begin
         b   = int'($urandom_range(0, 8));
         top = 6 + 18 * (b / 3);
         x   = ($urandom_range(0, 1) == 0) ? m_fire_x[b] : m_water_x[b];
         x   = (x + int'($urandom_range(0, 9)) - 1 + 96) % 96;
         y   = top + int'($urandom_range(0, 9)) - 1;
         return y * 96 + x;
      end
      b   = int'($urandom_range(0, 5));
      top = 6 + 18 * (b % 3);
      x   = ((b < 3) ? 24 : 70) + int'($urandom_range(0, 3)) - 1;
      y   = top - 5 + int'($urandom_range(0, 17));
      return y * 96 + x;
   endfunction

   function automatic logic [6:0] rand_pos();
      if ($urandom_range(0, 3) == 0) return 7'($urandom_range(0, 127));
      return 7'($urandom_range(0, 88));
   endfunction

   // Monitor: compares every output two cycles after its pixel_index was driven.
   always @(negedge clk_6p25MHz) begin
      if (sb.size() > 0 && sb[0].issue + 2 <= cyc) begin
         txn_t t;
         t = sb.pop_front();
         n_checks++;
         if (t.issue + 2 != cyc || pixel_data !== t.exp) begin
            n_fail++;
            $display("FAIL pixel idx=%0d got=%h exp=%h cyc=%0d", t.idx, pixel_data, t.exp, cyc);
         end else begin
            $display("ok   pixel idx=%0d data=%h", t.idx, pixel_data);
         end
      end
   end

   initial begin
      model_reset();
      pixel_index = 13'd600;
      FireBall_EN = 9'b1;
      leftX_fb[6:0] = 7'd17;
      repeat (3) @(negedge clk_6p25MHz);
      chk("reset_state", pixel_data, COL_BG);
      reset_n = 1'b1;

      // Before the first frame_begin nothing is drawn, even with inputs set.
      read_px(6*96 + 17);
      read_px(6*96 + 20);

      frame_pulse();
      read_px(6*96 + 17); read_px(6*96 + 25); read_px(6*96 + 24);
      read_px(6*96 + 16); read_px(13*96 + 17); read_px(14*96 + 17); read_px(5*96 + 20);

      FireBall_EN = 9'b1_0000; WaterBall_EN = 9'b1_0000;
      leftX_fb = '0; leftX_wb = '0;
      leftX_fb[34:28] = 7'd50; leftX_wb[34:28] = 7'd50;
      frame_pulse();
      read_px(24*96 + 52); read_px(31*96 + 57); read_px(32*96 + 52);
      FireBall_EN = 9'b0;
      frame_pulse();
      read_px(24*96 + 52); read_px(24*96 + 49);

      FireBall_EN = 9'b1; leftX_fb[6:0] = 7'd17;
      frame_pulse();
      leftX_fb[6:0] = 7'd40;
      read_px(6*96 + 17); read_px(6*96 + 45);
      frame_pulse();
      read_px(6*96 + 17); read_px(6*96 + 45);

      FireBall_EN = '0; WaterBall_EN = '0;
      frame_pulse();
      shield_pulse(3, 100);
      read_px(2*96 + 70); read_px(2*96 + 71); read_px(1*96 + 70);
      read_px(17*96 + 70); read_px(18*96 + 70); read_px(2*96 + 72); read_px(2*96 + 69);
      for (int f = 0; f < 7; f++) begin
         frame_pulse();
         read_px(2*96 + 70);
      end

      shield_with_frame(0);
      read_px(10*96 + 24);
      for (int f = 0; f < 3; f++) begin
         frame_pulse();
         read_px(10*96 + 25);
      end
      shield_pulse(0, 5);
      read_px(10*96 + 24);
      frame_pulse();
      read_px(10*96 + 24);

      read_px(6200); read_px(6144); read_px(6143); read_px(8191);

      for (int it = 0; it < 40; it++) begin
         FireBall_EN  = 9'($urandom);
         WaterBall_EN = 9'($urandom);
         for (int i = 0; i < 9; i++) begin
            leftX_fb[7*i +: 7] = rand_pos();
            leftX_wb[7*i +: 7] = rand_pos();
         end
         if ($urandom_range(0, 2) == 0) shield_pulse(int'($urandom_range(0, 5)), int'($urandom_range(3, 8)));
         if ($urandom_range(0, 5) == 0) shield_with_frame(int'($urandom_range(0, 5)));
         else frame_pulse();
         for (int r = 0; r < 30; r++) read_px(pick_idx());
         drain();
      end

      // Reset in the middle of an active shield and a drawn ball.
      FireBall_EN = 9'b1; leftX_fb[6:0] = 7'd10;
      shield_pulse(4, 5);
      frame_pulse();
      read_px(22*96 + 70);
      drain();
      chk("pre_reset", pixel_data, model_pixel(22*96 + 70));
      @(negedge clk_6p25MHz);
      reset_n = 1'b0;
      #1;
      chk("async_reset", pixel_data, COL_BG);
      model_reset();
      repeat (2) @(negedge clk_6p25MHz);
      reset_n = 1'b1;
      read_px(22*96 + 70); read_px(6*96 + 12);
      frame_pulse();
      read_px(22*96 + 70); read_px(6*96 + 12);
      shield_pulse(1, 4);
      read_px(20*96 + 25);

      drain();
      drain();
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pokemon_renderer.md
POKEMON_RENDERER -- requirements
Module: pokemon_renderer

Interface
REQ-001 SHALL have parameter SHIELD_FRAMES, default 4'd6, number of OLED frames a shield stays drawn after a hit.
REQ-002 SHALL have parameters COL_FIRE 16'hF800, COL_WATER 16'h001F, COL_SHIELD 16'hFFE0, COL_BG 16'h0000 (RGB565).
REQ-003 SHALL have port clk_6p25MHz, input, 1, OLED pixel clock and the only clock.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port frame_begin, input, 1, one-cycle pulse at the start of each OLED frame.
REQ-006 SHALL have port pixel_index, input, 13, OLED pixel address 0..6143, row-major on a 96x64 screen.
REQ-007 SHALL have ports FireBall_EN and WaterBall_EN, input, 9 each, ball enables; index i sits in lane i/3.
REQ-008 SHALL have ports leftX_fb and leftX_wb, input, 63 each, packed 7-bit left X; ball i occupies bits [7i+6:7i].
REQ-009 SHALL have port Shield_EN, input, 6, shield requests from the 20 Hz logic domain; bits 0-2 Charmander lanes 0-2, bits 3-5 Squirtle lanes 0-2.
REQ-010 SHALL have port pixel_data, output, 16, RGB565 colour for the pixel_index presented two cycles earlier.

Function
REQ-011 SHALL pass Shield_EN through a 2-flop synchronizer per bit, then rising-edge detect each bit against a third flop.
REQ-012 On frame_begin, SHALL snapshot FireBall_EN, WaterBall_EN, leftX_fb and leftX_wb; drawing SHALL use only the snapshot, so a frame never tears.
REQ-013 Each shield SHALL have a 4-bit timer; on a detected rising edge it SHALL load SHIELD_FRAMES, otherwise on frame_begin it SHALL decrement when nonzero and saturate at 0.
REQ-014 If an edge and frame_begin coincide, the load SHALL win (no decrement that cycle).
REQ-015 A new edge while a timer is nonzero SHALL reload it to SHIELD_FRAMES (retrigger).
REQ-016 Pipeline stage 1 SHALL register x = pixel_index % 96 and y = pixel_index / 96; pixel_index >= 6144 SHALL be flagged out-of-range.
REQ-017 Pipeline stage 2 SHALL compute the colour and register it to pixel_data; total latency is exactly 2 cycles and the pipeline never stalls.
REQ-018 Lane top row SHALL be 6, 24 or 42 for lanes 0, 1, 2.
REQ-019 A ball SHALL cover leftX <= x <= leftX+7 and top <= y <= top+7, and only when its snapshot enable is 1; leftX+7 SHALL be computed at 8 bits (no wrap).
REQ-020 A Charmander shield SHALL cover x in 24..25; a Squirtle shield SHALL cover x in 70..71; each covers lane top-4 <= y <= top+11 while its timer is nonzero.
REQ-021 Colour priority SHALL be shield > fireball > waterball > COL_BG; overlapping fire and water draw COL_FIRE.
REQ-022 An out-of-range pixel SHALL output COL_BG.

Reset
REQ-023 reset_n low SHALL asynchronously clear pixel_data, both pipeline stages, the snapshot registers (enables 0, positions 0), all synchronizer and edge flops, and all shield timers to 0.
REQ-024 After reset release, output SHALL be COL_BG until the first frame_begin loads a snapshot; a shield edge SHALL still be honoured before that.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no residual shield or ball drawing after release.

Configuration
REQ-026 With SHIELD_BLINK_EN defined, an active shield SHALL draw only on frames where timer bit 0 is 1 (blink); with SHIELD_BLINK_EN undefined, it SHALL draw on every frame where the timer is nonzero.

Verification
REQ-027 FireBall_EN=9'b1, leftX_fb[6:0]=17, frame_begin, then pixel_index=6*96+17 -> pixel_data=16'hF800 two cycles later; index 6*96+25 -> 16'h0000.
REQ-028 WaterBall_EN bit 4 set, leftX_wb ball 4 = 50, FireBall_EN bit 4 set, leftX_fb ball 4 = 50, frame_begin, then index 24*96+52 -> 16'hF800 (fire over water).
REQ-029 Shield_EN[3] pulse held 100 cycles -> after sync, index 2*96+70 reads 16'hFFE0; after 6 frame_begin pulses it reads 16'h0000 (macro undefined).
REQ-030 Change leftX_fb mid-frame without frame_begin -> output unchanged until the next frame_begin.
REQ-031 Apply pixel_index=6200 -> 16'h0000; assert reset_n low mid-shield -> pixel_data=0 immediately and timers=0 after release.
REQ-032 With SHIELD_BLINK_EN defined, run the REQ-029 stimulus -> shield visible on frames with timer 5, 3, 1 only.
